// File: rtl/io_cycle_initiator_if.sv
// Request/response handshake and I/O bus signals of io_cycle_initiator.
// The master modport is the initiator's view: it accepts requests, returns
// responses and drives the port-space bus. The slave modport is the mirror
// view used by whatever sits on the other side.
interface io_cycle_initiator_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_port;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [7:0] address;
  logic       iowrite;
  logic       ioread;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] din;
  logic       io_wait;

  modport master (
    input  req_valid, req_write, req_port, req_wdata, din, io_wait,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address, iowrite, ioread, dout, dout_oe
  );

  modport slave (
    output req_valid, req_write, req_port, req_wdata, din, io_wait,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           address, iowrite, ioread, dout, dout_oe
  );
endinterface

// File: rtl/io_cycle_initiator.sv
// Bus-master side of the 8-bit I/O port space. Turns one request into a
// timed SETUP / STROBE / HOLD cycle on address, iowrite/ioread and dout, then
// returns a one-cycle response. Define IO_CYCLE_WAIT_EN to honour io_wait
// (strobe stretching with a bounded timeout); otherwise io_wait is ignored.
module io_cycle_initiator #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input logic                  clock,
  input logic                  reset_n,
  io_cycle_initiator_if.master bus
);
  localparam logic [7:0] SetupLoad  = 8'(SETUP_CYC);
  localparam logic [7:0] StrobeLoad = 8'(STROBE_CYC);
  localparam logic [7:0] HoldLoad   = 8'(HOLD_CYC);
`ifdef IO_CYCLE_WAIT_EN
  localparam logic [7:0] WaitLoad   = 8'(WAIT_TIMEOUT);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
`ifdef IO_CYCLE_WAIT_EN
    WAITST = 3'd3,
`endif
    HOLD   = 3'd4,
    RESP   = 3'd5
  } stateType;

  stateType   state;
  stateType   nextState;
  logic [7:0] cnt;         // shared phase down-counter
  logic [7:0] cntLoad;
  logic       loadCnt;
  logic       decCnt;
  logic       accept;
  logic       sampleDin;
  logic [7:0] addrReg;
  logic [7:0] doutReg;
  logic       writeFlag;
  logic [7:0] readReg;
  logic       strobeOn;
`ifdef IO_CYCLE_WAIT_EN
  logic       setTimeout;
  logic       timeoutFlag;
`else
  logic       unusedWait;
`endif

  // State register; reset aborts any cycle in flight without a response.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement or process order.
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state and counter control for the phase sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    nextState = state;
    cntLoad   = '0;
    loadCnt   = 1'b0;
    decCnt    = 1'b0;
    accept    = 1'b0;
    sampleDin = 1'b0;
`ifdef IO_CYCLE_WAIT_EN
    setTimeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          loadCnt   = 1'b1;
          cntLoad   = SetupLoad;
          nextState = SETUP;
        end
      end
      SETUP: begin
        if (cnt == 8'd1) begin
          loadCnt   = 1'b1;
          cntLoad   = StrobeLoad;
          nextState = STROBE;
        end else begin
          decCnt = 1'b1;
        end
      end
      STROBE: begin
        if (cnt == 8'd1) begin
          loadCnt   = 1'b1;
          cntLoad   = HoldLoad;
          sampleDin = 1'b1;
          nextState = HOLD;
`ifdef IO_CYCLE_WAIT_EN
          // Peripheral not ready at the end of the minimum width: stretch.
          if (bus.io_wait) begin
            sampleDin = 1'b0;
            cntLoad   = WaitLoad;
            nextState = WAITST;
          end
`endif
        end else begin
          decCnt = 1'b1;
        end
      end
`ifdef IO_CYCLE_WAIT_EN
      WAITST: begin
        if (!bus.io_wait) begin
          loadCnt   = 1'b1;
          cntLoad   = HoldLoad;
          sampleDin = 1'b1;
          nextState = HOLD;
        end else if (cnt == 8'd1) begin
          loadCnt    = 1'b1;
          cntLoad    = HoldLoad;
          setTimeout = 1'b1;
          nextState  = HOLD;
        end else begin
          decCnt = 1'b1;
        end
      end
`endif
      HOLD: begin
        if (cnt == 8'd1) nextState = RESP;
        else             decCnt    = 1'b1;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, phase counter and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      addrReg   <= '0;
      doutReg   <= '0;
      writeFlag <= 1'b0;
      readReg   <= '0;
    end else begin
      if (accept) begin
        addrReg   <= bus.req_port;
        doutReg   <= bus.req_wdata;
        writeFlag <= bus.req_write;
        readReg   <= '0;           // writes report 0x00
      end
      if (loadCnt)     cnt <= cntLoad;
      else if (decCnt) cnt <= cnt - 8'd1;
      if (sampleDin && !writeFlag) readReg <= bus.din;
`ifdef IO_CYCLE_WAIT_EN
      if (setTimeout && !writeFlag) readReg <= 8'hFF;
`endif
    end
  end

`ifdef IO_CYCLE_WAIT_EN
  // Timeout flag, cleared per request and set when the wait budget runs out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        timeoutFlag <= 1'b0;
    else if (accept)     timeoutFlag <= 1'b0;
    else if (setTimeout) timeoutFlag <= 1'b1;
  end

  assign strobeOn        = (state == STROBE) || (state == WAITST);
  assign bus.rsp_timeout = timeoutFlag;
`else
  assign strobeOn        = (state == STROBE);
  assign bus.rsp_timeout = 1'b0;
  assign unusedWait      = &{1'b0, bus.io_wait, 8'(WAIT_TIMEOUT)};
`endif

  // Strobes decode straight from state so reset drops them immediately.
  assign bus.iowrite   = strobeOn &  writeFlag;
  assign bus.ioread    = strobeOn & ~writeFlag;
  assign bus.dout_oe   = writeFlag && (state != IDLE) && (state != RESP);
  assign bus.address   = addrReg;
  assign bus.dout      = doutReg;
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = readReg;
endmodule

// File: doc/io_cycle_initiator.md
Name: io_cycle_initiator

Overview:
- Bus-master side of the 8-bit I/O port space: turns one request (port, read/write, data) into a timed I/O cycle on address[7:0] / iowrite / ioread.
- These are the signals the port decoder consumes.
- Lets on-chip masters (monitor/debug UART, boot sequencer) reach LEDs, SD/SPI, RTC, MMU and the other ports without a CPU cycle.
- Sits between the internal request source and the shared I/O bus mux.

Parameters:
- SETUP_CYC, 1: cycles address/data are stable before the strobe (1..255).
- STROBE_CYC, 4: minimum cycles iowrite/ioread is high (1..255).
- HOLD_CYC, 1: cycles address/data are held after the strobe drops (1..255).
- WAIT_TIMEOUT, 255: maximum extra strobe cycles while io_wait is high (1..255).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  initiator idle, request accepted when valid&ready
- req_write  in  1  1=OUT cycle, 0=IN cycle
- req_port  in  8  I/O port number
- req_wdata  in  8  OUT data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  IN data (0x00 after a write)
- rsp_timeout  out  1  qualified by rsp_valid; wait timeout occurred
- address  out  8  I/O port address to decoder
- iowrite  out  1  sOUT strobe
- ioread  out  1  sINP strobe
- dout  out  8  write data to bus
- dout_oe  out  1  dout drive enable (writes only, SETUP..HOLD)
- din  in  8  read data from bus mux
- io_wait  in  1  peripheral wait request (active high)

Behaviour:
- Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0x00; rsp_timeout=0; address=0x00; iowrite=0; ioread=0; dout=0x00; dout_oe=0.
- Reset is asynchronous. Asserting it mid-cycle drops strobes and dout_oe immediately and returns to IDLE. No rsp_valid is issued for the aborted request.
- States: IDLE, SETUP, STROBE, WAITST, HOLD, RESP. A single 8-bit down-counter serves all phases.
- IDLE:
  - req_ready=1.
  - On req_valid: latch port, write flag and wdata; load counter=SETUP_CYC; go to SETUP.
  - address and dout are registered from the latched values, so they change on the cycle after acceptance.
- SETUP:
  - address = latched port; dout_oe = write flag; strobes low.
  - After SETUP_CYC cycles, load STROBE_CYC and go to STROBE.
- STROBE:
  - iowrite (write) or ioread (read) is high; exactly one strobe, never both.
  - On the last counted cycle:
    - io_wait=0 → sample din into the read register, load HOLD_CYC, go to HOLD.
    - io_wait=1 → go to WAITST with timeout counter = WAIT_TIMEOUT.
- WAITST:
  - Strobe stays high.
  - When io_wait=0: sample din, go to HOLD.
  - When the counter expires with io_wait still high: set the timeout flag, read register=0xFF, go to HOLD.
- HOLD:
  - Strobes low; address and dout/dout_oe unchanged.
  - After HOLD_CYC cycles go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata = read register (0x00 for writes); rsp_timeout = flag.
  - No backpressure on the response. Next state is IDLE.
  - dout_oe drops on entry to RESP.
- address holds its last value in IDLE; strobes guarantee the decoder stays inactive.
- req_valid outside IDLE is ignored (req_ready=0). The earliest next acceptance is the cycle after RESP.
- Default write timing, acceptance at T0:
  - SETUP T1
  - iowrite high T2–T5
  - HOLD T6
  - rsp_valid T7
  - req_ready high again T8

Optional Feature:
- Macro IO_CYCLE_WAIT_EN.
- Defined: io_wait honoured as above, with WAITST and timeout.
- Undefined:
  - io_wait is ignored and WAITST is not built.
  - Strobe width is always exactly STROBE_CYC.
  - rsp_timeout is tied 0.

Test Plan:
- Write port 0x06, data 0xA5, defaults:
  - address=0x06 from T1 to T7 (T7 being the first HOLD-exit cycle); dout=0xA5 with dout_oe=1 T1–T6.
  - iowrite high T2–T5, ioread never high.
  - rsp_valid single pulse at T7 with rsp_rdata=0x00, rsp_timeout=0.
- Read port 0x6E with din=0x3C:
  - ioread high 4 cycles, iowrite never high, dout_oe=0 throughout.
  - rsp_rdata=0x3C, rsp_timeout=0.
- IO_CYCLE_WAIT_EN, read port 0x6F, io_wait high for 3 cycles from the last strobe cycle, din=0x81 when released:
  - ioread high 7 cycles; rsp_rdata=0x81; rsp_timeout=0.
- IO_CYCLE_WAIT_EN, WAIT_TIMEOUT=5, io_wait stuck high:
  - strobe extended 5 cycles then drops; rsp_rdata=0xFF; rsp_timeout=1.
- reset_n pulsed low during the strobe:
  - iowrite/ioread/dout_oe go 0 asynchronously, no rsp_valid.
  - req_ready=1 after release; a following write to 0xFF completes normally.
- req_valid held high for two back-to-back requests (write 0x07=0x12, then read 0x02):
  - second request accepted only the cycle after the first rsp_valid.
  - never both strobes high; each response matches its request.
